max7219_frame_sched: RTL and testbench
======================================

MAX7219_FRAME_SCHED -- requirements
Module: max7219_frame_sched

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of display digits refreshed per frame; legal range 1..8.
REQ-002 Parameter DECODE_MODE, default 8'h00, value written to the MAX7219 decode-mode register (0x09).
REQ-003 i_clk  in  1  system clock, ~10 MHz.
REQ-004 i_reset  in  1  synchronous reset, active-high; all registers reset on the i_clk edge where i_reset=1.
REQ-005 i_en  in  1  when low, no new frame or intensity word is started.
REQ-006 i_update_stb  in  1  one-cycle request to refresh all digits.
REQ-007 i_intensity  in  4  requested display brightness.
REQ-008 o_digit_sel  out  3  digit index presented to the digit source.
REQ-009 i_digit_data  in  8  segment byte for o_digit_sel, valid one cycle after o_digit_sel changes.
REQ-010 o_tx_word  out  16  MAX7219 command word {addr[15:8], data[7:0]} to the serial shifter.
REQ-011 o_tx_valid  out  1  o_tx_word is valid.
REQ-012 i_tx_ready  in  1  serial shifter accepts a word on an edge where o_tx_valid=1 and i_tx_ready=1.
REQ-013 o_init_done  out  1  init sequence complete; stays high until reset.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 States: INIT, IDLE, INTEN, FETCH, SEND; exactly one active.
REQ-016 Handshake: once o_tx_valid rises, o_tx_word SHALL stay stable and o_tx_valid high until the accepting edge; o_tx_valid drops the cycle after acceptance unless the next word is already issued.
REQ-017 INIT sends, in order: 16'h0F00, 16'h0C00, {8'h09,DECODE_MODE}, {8'h0A,4'h0,i_intensity}, {8'h0B,5'h0,NUM_DIGITS-1}, 16'h0C01; then o_init_done=1 and go to IDLE.
REQ-018 INIT ignores i_en; i_update_stb arriving during INIT sets the pending flag.
REQ-019 Pending flag: set by i_update_stb in any state; cleared when a frame starts (IDLE->FETCH); multiple strobes coalesce into one frame.
REQ-020 Intensity shadow register holds the last intensity sent; written on acceptance of any 0x0A word.
REQ-021 IDLE priority (i_en=1): i_intensity != shadow -> INTEN; else pending or i_update_stb -> FETCH with digit counter 0; else stay.
REQ-022 INTEN issues {8'h0A,4'h0,i_intensity} sampled on entry, returns to IDLE after acceptance.
REQ-023 FETCH drives o_digit_sel=counter for one cycle, then SEND registers {4'h0, counter+1, i_digit_data} into o_tx_word.
REQ-024 Latency: strobe seen in IDLE at edge N -> o_digit_sel=0 from N+1 -> o_tx_valid=1 with digit-0 word from N+2.
REQ-025 After acceptance in SEND: counter < NUM_DIGITS-1 -> increment, FETCH; counter = NUM_DIGITS-1 -> IDLE.
REQ-026 Intensity changes mid-frame are deferred to IDLE; a frame is never interrupted.
REQ-027 i_en falling mid-frame: frame completes; i_en=0 in IDLE holds IDLE with pending retained.
REQ-028 Digit counter 3 bits, addr field = counter+1 in range 1..8; no wrap beyond NUM_DIGITS-1.

Reset
REQ-029 On reset: state INIT at first word, o_tx_valid=0, o_tx_word=16'h0000, o_digit_sel=0, o_init_done=0, o_busy=1, pending=0, shadow=4'h0, counter=0.
REQ-030 Reset asserted mid-handshake aborts the word; INIT restarts from 16'h0F00 the cycle after reset deasserts.

Verification
REQ-031 Reset, i_tx_ready=1, i_intensity=4'h7 -> six words 0F00,0C00,0900,0A07,0B07,0C01; o_init_done=1 after sixth.
REQ-032 Idle, digit source returns 8'h30+d, i_update_stb pulse -> words 0130,0231,...,0837 in order; o_busy low after last acceptance.
REQ-033 i_tx_ready low 5 cycles during digit 2 -> o_tx_word=0332 stable with o_tx_valid high throughout; no word lost or duplicated.
REQ-034 Three i_update_stb pulses during a frame -> exactly one further frame follows.
REQ-035 i_intensity 7->C during a frame -> 0A0C sent after 0837, before the next frame.
REQ-036 Reset pulse after third INIT word accepted -> sequence restarts at 0F00; o_init_done=0 until the new sixth word.

Source files
------------

// File: rtl/max7219_frame_sched.sv
// MAX7219 command scheduler: runs the power-up init sequence, then emits
// intensity updates and full digit frames as 16-bit words to a serial shifter.
module max7219_frame_sched #(
    parameter int         NUM_DIGITS  = 8,
    parameter logic [7:0] DECODE_MODE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_update_stb,
    input  logic [3:0]  i_intensity,
    output logic [2:0]  o_digit_sel,
    input  logic [7:0]  i_digit_data,
    output logic [15:0] o_tx_word,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_init_done,
    output logic        o_busy
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_INTEN, S_FETCH, S_SEND} state_t;

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [2:0] LAST_INIT  = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic [2:0]  counter_q, counter_d;
    logic [15:0] tx_word_q, tx_word_d;
    logic        tx_valid_q, tx_valid_d;
    logic        pending_q, pending_d;
    logic [3:0]  shadow_q, shadow_d;
    logic        init_done_q, init_done_d;
    logic        accept;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
        case (idx)
            3'd0:    return 16'h0F00;
            3'd1:    return 16'h0C00;
            3'd2:    return {8'h09, DECODE_MODE};
            3'd3:    return {8'h0A, 4'h0, inten};
            3'd4:    return {8'h0B, 5'h00, LAST_DIGIT};
            default: return 16'h0C01;
        endcase
    endfunction

    assign accept = tx_valid_q && i_tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational blocks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_INIT;
            init_idx_q  <= 3'd0;
            counter_q   <= 3'd0;
            tx_word_q   <= 16'h0000;
            tx_valid_q  <= 1'b0;
            pending_q   <= 1'b0;
            shadow_q    <= 4'h0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            counter_q   <= counter_d;
            tx_word_q   <= tx_word_d;
            tx_valid_q  <= tx_valid_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (accept && init_idx_q == LAST_INIT) state_d = S_IDLE;
            S_IDLE: begin
                if (i_en) begin
                    if (i_intensity != shadow_q)          state_d = S_INTEN;
                    else if (pending_q || i_update_stb)   state_d = S_FETCH;
                end
            end
            S_INTEN: if (accept) state_d = S_IDLE;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (accept) state_d = (counter_q == LAST_DIGIT) ? S_IDLE : S_FETCH;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        init_idx_d  = init_idx_q;
        counter_d   = counter_q;
        tx_word_d   = tx_word_q;
        tx_valid_d  = tx_valid_q;
        pending_d   = pending_q || i_update_stb;
        shadow_d    = shadow_q;
        init_done_d = init_done_q;

        if (accept && tx_word_q[15:8] == 8'h0A) shadow_d = tx_word_q[3:0];

        case (state_q)
            S_INIT: begin
                if (!tx_valid_q) begin
                    tx_word_d  = init_word(init_idx_q, i_intensity);
                    tx_valid_d = 1'b1;
                end else if (accept) begin
                    if (init_idx_q == LAST_INIT) begin
                        tx_valid_d  = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        // Next init word goes out back-to-back with the accepted one.
                        init_idx_d = init_idx_q + 3'd1;
                        tx_word_d  = init_word(init_idx_q + 3'd1, i_intensity);
                    end
                end
            end
            S_IDLE: begin
                if (state_d == S_INTEN) begin
                    tx_word_d  = {8'h0A, 4'h0, i_intensity};
                    tx_valid_d = 1'b1;
                end else if (state_d == S_FETCH) begin
                    pending_d = 1'b0;
                    counter_d = 3'd0;
                end
            end
            S_INTEN: if (accept) tx_valid_d = 1'b0;
            S_FETCH: begin
                tx_word_d  = {4'h0, {1'b0, counter_q} + 4'd1, i_digit_data};
                tx_valid_d = 1'b1;
            end
            S_SEND: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    if (counter_q != LAST_DIGIT) counter_d = counter_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != S_IDLE);
        o_digit_sel = counter_q;
        o_tx_word   = tx_word_q;
        o_tx_valid  = tx_valid_q;
        o_init_done = init_done_q;
    end

endmodule

// File: tb/tb_max7219_frame_sched.sv
// Directed bench for max7219_frame_sched: init sequence, frames, backpressure,
// strobe coalescing, deferred intensity, enable gating and reset mid-init.
module tb_max7219_frame_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        update_stb;
    logic [3:0]  intensity;
    logic [2:0]  digit_sel;
    logic [7:0]  digit_data;
    logic [15:0] tx_word;
    logic        tx_valid;
    logic        tx_ready;
    logic        init_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    // Digit source returns ASCII '0'+index.
    assign digit_data = 8'h30 + {5'd0, digit_sel};

    max7219_frame_sched #(.NUM_DIGITS(8), .DECODE_MODE(8'h00)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_en         (en),
        .i_update_stb (update_stb),
        .i_intensity  (intensity),
        .o_digit_sel  (digit_sel),
        .i_digit_data (digit_data),
        .o_tx_word    (tx_word),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_init_done  (init_done),
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a presented word with ready high, checks it, steps past acceptance.
    task automatic expect_word(input string tag, input logic [15:0] exp);
        int n = 0;
        while (!(tx_valid === 1'b1 && tx_ready === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 16'(tx_valid), 16'd1);
        else          check(tag, tx_word, exp);
        @(negedge clk);
    endtask

    task automatic expect_digit(input string tag, input int d);
        expect_word($sformatf("%s_d%0d", tag, d), {4'h0, 4'(d + 1), 8'h30 + 8'(d)});
    endtask

    task automatic run_frame(input string tag);
        for (int d = 0; d < 8; d++) expect_digit(tag, d);
    endtask

    task automatic pulse_stb();
        update_stb = 1'b1;
        @(negedge clk);
        update_stb = 1'b0;
    endtask

    task automatic run_init(input string tag, input logic [3:0] inten);
        logic [15:0] words [6];
        words = '{16'h0F00, 16'h0C00, 16'h0900, {12'h0A0, inten}, 16'h0B07, 16'h0C01};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check({tag, "_done_before_last"}, 16'(init_done), 16'd0);
            expect_word($sformatf("%s_w%0d", tag, i), words[i]);
        end
        check({tag, "_done_after"}, 16'(init_done), 16'd1);
        check({tag, "_busy_after"}, 16'(busy), 16'd0);
    endtask

    initial begin
        logic stable;
        logic quiet;

        reset = 1'b1; en = 1'b1; update_stb = 1'b0; intensity = 4'h7; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 16'(tx_valid), 16'd0);
        check("rst_word", tx_word, 16'h0000);
        check("rst_sel", 16'(digit_sel), 16'd0);
        check("rst_done", 16'(init_done), 16'd0);
        check("rst_busy", 16'(busy), 16'd1);
        reset = 1'b0;

        run_init("init", 4'h7);

        // Strobe latency: sel=0 one edge after the strobe, word valid the edge after.
        repeat (2) @(negedge clk);
        pulse_stb();
        check("lat_sel", 16'(digit_sel), 16'd0);
        check("lat_busy", 16'(busy), 16'd1);
        check("lat_valid_early", 16'(tx_valid), 16'd0);
        @(negedge clk);
        check("lat_valid", 16'(tx_valid), 16'd1);
        check("lat_word", tx_word, 16'h0130);
        run_frame("frame1");
        check("frame1_idle", 16'(busy), 16'd0);

        // Backpressure on digit 2.
        pulse_stb();
        expect_digit("bp", 0);
        expect_digit("bp", 1);
        tx_ready = 1'b0;
        @(negedge clk);
        stable = 1'b1;
        repeat (5) begin
            if (!(tx_valid === 1'b1 && tx_word === 16'h0332)) stable = 1'b0;
            @(negedge clk);
        end
        check("bp_stable", 16'(stable), 16'd1);
        tx_ready = 1'b1;
        for (int d = 2; d < 8; d++) expect_digit("bp", d);

        // Three strobes mid-frame coalesce into exactly one more frame.
        pulse_stb();
        expect_digit("coal", 0);
        pulse_stb();
        expect_digit("coal", 1);
        pulse_stb();
        expect_digit("coal", 2);
        pulse_stb();
        for (int d = 3; d < 8; d++) expect_digit("coal", d);
        run_frame("coal2");
        quiet = 1'b1;
        repeat (12) begin
            if (tx_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("coal_no_third", 16'(quiet), 16'd1);

        // Intensity change mid-frame is deferred until after the frame.
        pulse_stb();
        expect_digit("int", 0);
        intensity = 4'hC;
        pulse_stb();
        for (int d = 1; d < 8; d++) expect_digit("int", d);
        expect_word("int_word", 16'h0A0C);
        run_frame("int_next");
        check("int_idle", 16'(busy), 16'd0);

        // Enable low holds IDLE with the request pending.
        en = 1'b0;
        pulse_stb();
        quiet = 1'b1;
        repeat (6) begin
            if (tx_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("en_hold", 16'(quiet), 16'd1);
        en = 1'b1;
        run_frame("en_frame");

        // Reset after the third init word aborts and restarts the sequence.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expect_word("rinit_w0", 16'h0F00);
        expect_word("rinit_w1", 16'h0C00);
        expect_word("rinit_w2", 16'h0900);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", 16'(tx_valid), 16'd0);
        check("abort_word", tx_word, 16'h0000);
        check("abort_done", 16'(init_done), 16'd0);
        reset = 1'b0;
        run_init("reinit", 4'hC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
